// File: rtl/pin_sequencer.sv
`default_nettype none
// ============================================================================
// pin_sequencer : WIDTH-bit pin bank driven by valid/ready commands
//                 (set / clear / toggle / masked write / timed pulse).
// Optional macro PIN_SEQUENCER_LEGACY_TOGGLE_EN adds an edge-triggered toggle.
// Revision: 1.0
// ============================================================================
module pin_sequencer #(
  parameter int                 WIDTH       = 64,
  parameter int                 PULSE_W     = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_mask,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic [PULSE_W-1:0] cmd_len,
`ifdef PIN_SEQUENCER_LEGACY_TOGGLE_EN
  input  logic [WIDTH-1:0]   toggle_mask,
  input  logic               toggle_enable,
`endif
  output logic [WIDTH-1:0]   output_pins,
  output logic               busy,
  output logic               pulse_done
);

  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLR    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_WRITE  = 3'd4;
  localparam logic [2:0] OP_PULSE  = 3'd5;

  localparam logic [PULSE_W-1:0] CNT_ONE = {{(PULSE_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  state_t             state;
  logic [PULSE_W-1:0] counter;
  logic [WIDTH-1:0]   pulse_mask;
  logic [WIDTH-1:0]   pins_next;
  logic [PULSE_W-1:0] len_eff;
  logic               accept;

  assign cmd_ready = ~busy & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  // A zero length still produces a one-cycle pulse.
  assign len_eff   = (cmd_len == '0) ? CNT_ONE : cmd_len;

`ifdef PIN_SEQUENCER_LEGACY_TOGGLE_EN
  logic toggle_prev;

  always_ff @(posedge clk) begin
    if (rst) toggle_prev <= 1'b0;
    else     toggle_prev <= toggle_enable;
  end
`endif

  always_comb begin
    pins_next = output_pins;
    if (state == IDLE) begin
      if (accept) begin
        case (cmd_op)
          OP_SET:    pins_next = output_pins | cmd_mask;
          OP_CLR:    pins_next = output_pins & ~cmd_mask;
          OP_TOGGLE: pins_next = output_pins ^ cmd_mask;
          OP_WRITE:  pins_next = (output_pins & ~cmd_mask) | (cmd_data & cmd_mask);
          OP_PULSE:  pins_next = output_pins ^ cmd_mask;
          default:   pins_next = output_pins;
        endcase
      end
    end else if (counter == CNT_ONE) begin
      pins_next = output_pins ^ pulse_mask;
    end
`ifdef PIN_SEQUENCER_LEGACY_TOGGLE_EN
    // Legacy toggle lands on top of whatever the command/restore produced.
    if (toggle_enable & ~toggle_prev) pins_next = pins_next ^ toggle_mask;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output_pins <= RESET_VALUE;
      busy        <= 1'b0;
      pulse_done  <= 1'b0;
      counter     <= '0;
      pulse_mask  <= '0;
      state       <= IDLE;
    end else begin
      output_pins <= pins_next;
      pulse_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (cmd_op == OP_PULSE)) begin
            pulse_mask <= cmd_mask;
            counter    <= len_eff;
            busy       <= 1'b1;
            state      <= PULSE;
          end
        end
        PULSE: begin
          if (counter == CNT_ONE) begin
            counter    <= '0;
            busy       <= 1'b0;
            pulse_done <= 1'b1;
            state      <= IDLE;
          end else begin
            counter <= counter - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pin_sequencer.sv
`default_nettype none
// tb_pin_sequencer : directed self-checking bench for pin_sequencer (WIDTH=8, RESET_VALUE=A5).
module tb_pin_sequencer;

  localparam int WIDTH   = 8;
  localparam int PULSE_W = 16;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [WIDTH-1:0]   cmd_mask;
  logic [WIDTH-1:0]   cmd_data;
  logic [PULSE_W-1:0] cmd_len;
  logic [WIDTH-1:0]   output_pins;
  logic               busy;
  logic               pulse_done;
`ifdef PIN_SEQUENCER_LEGACY_TOGGLE_EN
  logic [WIDTH-1:0]   toggle_mask;
  logic               toggle_enable;
`endif

  int n_cmp;
  int n_err;

  pin_sequencer #(
    .WIDTH       (WIDTH),
    .PULSE_W     (PULSE_W),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_mask    (cmd_mask),
    .cmd_data    (cmd_data),
    .cmd_len     (cmd_len),
`ifdef PIN_SEQUENCER_LEGACY_TOGGLE_EN
    .toggle_mask   (toggle_mask),
    .toggle_enable (toggle_enable),
`endif
    .output_pins (output_pins),
    .busy        (busy),
    .pulse_done  (pulse_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] m,
                       input logic [7:0] d, input logic [15:0] len);
    cmd_valid = v;
    cmd_op    = op;
    cmd_mask  = m;
    cmd_data  = d;
    cmd_len   = len;
  endtask

  task automatic idle_cmd();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 16'd0);
  endtask

  // Issue one command and return at the next falling edge (after its accept edge).
  task automatic one_cmd(input logic [2:0] op, input logic [7:0] m,
                         input logic [7:0] d, input logic [15:0] len);
    drive(1'b1, op, m, d, len);
    @(negedge clk);
    idle_cmd();
  endtask

  initial begin
    logic seen_done;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_cmd();
`ifdef PIN_SEQUENCER_LEGACY_TOGGLE_EN
    toggle_mask   = 8'h00;
    toggle_enable = 1'b0;
`endif

    // Reset: two cycles held
    @(negedge clk);
    @(negedge clk);
    check("rst_pins", output_pins, 8'hA5);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_done", 8'(pulse_done), 8'h00);
    check("rst_ready", 8'(cmd_ready), 8'h00);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 8'(cmd_ready), 8'h01);
    @(negedge clk);

    // Basic ops on consecutive cycles from 00
    one_cmd(3'd2, 8'hFF, 8'h00, 16'd0);
    check("clr_all", output_pins, 8'h00);
    drive(1'b1, 3'd1, 8'h0F, 8'h00, 16'd0);
    @(negedge clk); check("set_0f", output_pins, 8'h0F);
    drive(1'b1, 3'd2, 8'h03, 8'h00, 16'd0);
    @(negedge clk); check("clr_03", output_pins, 8'h0C);
    drive(1'b1, 3'd3, 8'hF0, 8'h00, 16'd0);
    @(negedge clk); check("tog_f0", output_pins, 8'hFC);
    drive(1'b1, 3'd4, 8'h3C, 8'hFF, 16'd0);
    @(negedge clk); check("wr_3c_ff", output_pins, 8'hFC);
    drive(1'b1, 3'd4, 8'h0F, 8'h05, 16'd0);
    @(negedge clk); check("wr_0f_05", output_pins, 8'hF5);
    drive(1'b1, 3'd6, 8'hFF, 8'hFF, 16'd0);
    @(negedge clk); check("reserved6", output_pins, 8'hF5);
    drive(1'b1, 3'd0, 8'hFF, 8'hFF, 16'd0);
    @(negedge clk); check("nop", output_pins, 8'hF5);
    check("nop_busy", 8'(busy), 8'h00);
    idle_cmd();

    // PULSE m=81 len=4 from 00
    one_cmd(3'd2, 8'hFF, 8'h00, 16'd0);
    one_cmd(3'd5, 8'h81, 8'h00, 16'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pulse4_pins_c%0d", i), output_pins, 8'h81);
      check($sformatf("pulse4_busy_c%0d", i), 8'(busy), 8'h01);
      check($sformatf("pulse4_ready_c%0d", i), 8'(cmd_ready), 8'h00);
      check($sformatf("pulse4_done_c%0d", i), 8'(pulse_done), 8'h00);
      @(negedge clk);
    end
    check("pulse4_restore", output_pins, 8'h00);
    check("pulse4_done", 8'(pulse_done), 8'h01);
    check("pulse4_busy_end", 8'(busy), 8'h00);
    check("pulse4_ready_end", 8'(cmd_ready), 8'h01);
    @(negedge clk);
    check("pulse4_done_1cyc", 8'(pulse_done), 8'h00);

    // PULSE len=0 with SET held during it
    one_cmd(3'd5, 8'h01, 8'h00, 16'd0);
    check("pulse0_pins", output_pins, 8'h01);
    check("pulse0_busy", 8'(busy), 8'h01);
    drive(1'b1, 3'd1, 8'h02, 8'h00, 16'd0);
    @(negedge clk);
    check("pulse0_restore", output_pins, 8'h00);
    check("pulse0_done", 8'(pulse_done), 8'h01);
    check("held_set_ready", 8'(cmd_ready), 8'h01);
    @(negedge clk);
    idle_cmd();
    check("held_set_pins", output_pins, 8'h02);
    check("held_set_done_low", 8'(pulse_done), 8'h00);

    // Pins outside the pulse mask are untouched
    one_cmd(3'd4, 8'hFF, 8'hA5, 16'd0);
    one_cmd(3'd5, 8'h0F, 8'h00, 16'd2);
    check("mask_c0", output_pins, 8'hAA);
    @(negedge clk);
    check("mask_c1", output_pins, 8'hAA);
    @(negedge clk);
    check("mask_restore", output_pins, 8'hA5);
    check("mask_done", 8'(pulse_done), 8'h01);

    // Zero-mask pulse still times out
    one_cmd(3'd5, 8'h00, 8'h00, 16'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("zmask_busy_c%0d", i), 8'(busy), 8'h01);
      check($sformatf("zmask_pins_c%0d", i), output_pins, 8'hA5);
      @(negedge clk);
    end
    check("zmask_done", 8'(pulse_done), 8'h01);
    check("zmask_busy_end", 8'(busy), 8'h00);

    // Reset in the middle of a long pulse
    one_cmd(3'd2, 8'hFF, 8'h00, 16'd0);
    one_cmd(3'd5, 8'h0F, 8'h00, 16'd10);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("abort_pre_pins", output_pins, 8'h0F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pins", output_pins, 8'hA5);
    check("abort_busy", 8'(busy), 8'h00);
    seen_done = pulse_done;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_done = seen_done | pulse_done;
    end
    check("abort_no_done", 8'(seen_done), 8'h00);
    check("abort_pins_hold", output_pins, 8'hA5);
    check("abort_busy_hold", 8'(busy), 8'h00);

`ifdef PIN_SEQUENCER_LEGACY_TOGGLE_EN
    one_cmd(3'd2, 8'hFF, 8'h00, 16'd0);
    toggle_mask   = 8'h01;
    toggle_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ltog_hold_c%0d", i), output_pins, 8'h01);
    end
    toggle_enable = 1'b0;
    one_cmd(3'd2, 8'hFF, 8'h00, 16'd0);
    check("ltog_cleared", output_pins, 8'h00);
    toggle_enable = 1'b1;
    one_cmd(3'd1, 8'h10, 8'h00, 16'd0);
    check("ltog_with_set", output_pins, 8'h11);
    check("ltog_busy", 8'(busy), 8'h00);
    toggle_enable = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pin_sequencer.md
Name: pin_sequencer

Overview:
Parametrised successor to the single-mask pin toggler. It drives a WIDTH-bit bank of output pins from a valid/ready command port. Supported operations are set, clear, toggle, masked write, and timed pulse. It sits between the host command decoder and the test-bench pin drivers. A timed pulse auto-restores its pins after a programmed cycle count and signals completion.

Parameters:
WIDTH, 64, number of output pins
PULSE_W, 16, width of pulse-length field and internal down-counter
RESET_VALUE, {WIDTH{1'b0}}, value loaded into output_pins on reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept command
cmd_op  input  3  opcode (see Behaviour)
cmd_mask  input  WIDTH  pins affected by command
cmd_data  input  WIDTH  write data (WRITE only)
cmd_len  input  PULSE_W  pulse length in cycles (PULSE only)
output_pins  output  WIDTH  registered pin bank
busy  output  1  high while a pulse is in progress
pulse_done  output  1  one-cycle strobe at pulse completion

Behaviour:
- Single clock clk; synchronous active-high reset rst. Reset state: output_pins=RESET_VALUE, busy=0, pulse_done=0, counter=0, FSM=IDLE.
- cmd_ready = ~busy & ~rst, combinational. A command is accepted on a rising edge where cmd_valid & cmd_ready.
- Opcodes; m=cmd_mask, P=output_pins:
  - 0 NOP: no change.
  - 1 SET: P|=m.
  - 2 CLR: P&=~m.
  - 3 TOGGLE: P^=m.
  - 4 WRITE: P=(P&~m)|(cmd_data&m).
  - 5 PULSE: P^=m; latch m into pulse_mask; load counter with cmd_len (cmd_len=0 treated as 1); go to PULSE.
  - 6,7 reserved: accepted, treated as NOP.
- Latency: an accepted command updates output_pins at the accepting edge, visible the following cycle.
- FSM:
  - IDLE: busy=0. PULSE opcode -> PULSE. All other opcodes stay in IDLE.
  - PULSE: busy=1, cmd_ready=0. Each edge: if counter==1, then P^=pulse_mask, pulse_done<=1, busy<=0, go to IDLE. Otherwise counter decrements.
  - Net result: masked pins hold the inverted value for exactly max(cmd_len,1) cycles.
- pulse_done is high for exactly one cycle: the first IDLE cycle after the restore. A command may be accepted in that same cycle.
- Pins outside pulse_mask are untouched during and at the end of a pulse.
- PULSE with mask=0: still runs the timed sequence and busy/pulse_done behave normally. The pins do not change.
- cmd_valid while busy: the command is not accepted. The requester must hold it until cmd_ready is high.
- Reset mid-pulse: the pulse is aborted, output_pins=RESET_VALUE, and no pulse_done is issued.
- Counter width is PULSE_W. cmd_len=all-ones gives 2^PULSE_W-1 cycles, with no wrap.

Optional Feature:
Macro PIN_SEQUENCER_LEGACY_TOGGLE_EN.
- Defined:
  - Adds inputs toggle_mask (WIDTH) and toggle_enable (1).
  - A rising edge of toggle_enable XORs toggle_mask into output_pins. The edge is detected against a registered previous value, which resets to 0.
  - Applies in any FSM state.
  - If it coincides with a command or a pulse restore, the command/restore result is computed first and toggle_mask is XORed on top, in the same edge.
  - Does not affect busy, cmd_ready or pulse_done.
- Undefined: the ports are absent and the behaviour is exactly as above.

Test Plan:
- WIDTH=8, RESET_VALUE=8'hA5; assert rst 2 cycles -> output_pins=A5, busy=0, pulse_done=0, cmd_ready=0 during rst, 1 after.
- From 00: SET m=0F, CLR m=03, TOGGLE m=F0, WRITE m=3C d=FF, issued on consecutive cycles -> pins 0F, 0C, FC, FC, each one cycle after its accept edge.
- Pins=00, PULSE m=81 len=4 -> pins=81 for exactly 4 cycles then 00; busy high those 4 cycles; pulse_done high 1 cycle after restore; cmd_ready=0 throughout.
- PULSE len=0 -> 1-cycle pulse. SET m=02 held valid during a pulse -> accepted only on the pulse_done cycle.
- Pins=00, PULSE m=0F len=10, assert rst at cycle 5 -> pins=RESET_VALUE next cycle, pulse_done never asserted, busy=0.
- With PIN_SEQUENCER_LEGACY_TOGGLE_EN: toggle_enable held high 3 cycles with toggle_mask=01 -> single toggle only. A rising edge coinciding with SET m=10 from 00 -> pins=11.
